uncached_dm_ctrl: RTL and testbench

Uncached data-memory request controller in the MEM stage. Converts an uncached load or store into a single transaction on the SRAM-like data bus. It returns a completion strobe and the load data, and the stall logic uses that strobe to release the pipeline. It holds the result until the pipeline advances, so a stall from another source never causes a re-issue.

---
 rtl/dm_uc_pkg.sv | 16 +
 rtl/uc_wr_tracker.sv | 27 ++
 rtl/uncached_dm_ctrl.sv | 157 +++++++++++++++
 tb/tb_uncached_dm_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_uc_pkg.sv
// Shared types for the uncached data-memory controller.
// State encoding and access-size constants.
package dm_uc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } uc_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/uc_wr_tracker.sv
// Outstanding posted-write flag: set when a store is accepted
// without its response, cleared by the next data_ok.
module uc_wr_tracker
    import dm_uc_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic i_set,
    input  logic i_clr,
    output logic o_pending
);

    logic r_pending;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 1'b0;
        end else if (i_set) begin
            r_pending <= 1'b1;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/uncached_dm_ctrl.sv
// Uncached MEM-stage load/store controller on the SRAM-like bus.
// Optional posted stores: UNCACHED_POSTED_WRITE_EN.
module uncached_dm_ctrl
    import dm_uc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                read,
    input  logic                write,
    input  logic                uncached,
    input  logic                cancel,
    input  logic                mem_advance,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [1:0]          data_sram_size,
    output logic [ADDR_W-1:0]   data_sram_addr,
    output logic [DATA_W/8-1:0] data_sram_wstrb,
    output logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                data_sram_addr_ok,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    output logic                uc_data_ok,
    output logic [DATA_W-1:0]   uc_rdata,
    output logic                uc_busy
);

`ifdef UNCACHED_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    uc_state_t             r_state;
    uc_state_t             w_state_nxt;
    logic                  r_kill;
    logic                  r_wr;
    logic [1:0]            r_size;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic                  w_start;
    logic                  w_go;
    logic                  w_kill;
    logic                  w_cap;
    logic                  w_outstanding;

    assign w_start = (read | write) & uncached & ~cancel;
    // A posted store's response in this cycle frees the bus for the next access.
    assign w_go    = w_start & (~w_outstanding | data_sram_data_ok);
    assign w_kill  = r_kill | cancel;
    assign w_cap   = data_sram_data_ok &
                     ((r_state == REQ & data_sram_addr_ok) | r_state == WAIT);

`ifdef UNCACHED_POSTED_WRITE_EN
    logic w_trk_set;

    assign w_trk_set = (r_state == REQ) & data_sram_addr_ok & r_wr &
                       ~data_sram_data_ok;

    uc_wr_tracker u_trk (
        .clk       (clk),
        .resetn    (resetn),
        .i_set     (w_trk_set),
        .i_clr     (data_sram_data_ok),
        .o_pending (w_outstanding)
    );
`else
    assign w_outstanding = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_go) w_state_nxt = REQ;
            end
            REQ: begin
                if (data_sram_addr_ok) begin
                    if (data_sram_data_ok)
                        w_state_nxt = w_kill ? IDLE : DONE;
                    else if (POSTED && r_wr)
                        w_state_nxt = w_kill ? IDLE : DONE;
                    else
                        w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (data_sram_data_ok) w_state_nxt = w_kill ? IDLE : DONE;
            end
            DONE: begin
                if (mem_advance | cancel) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_kill <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_kill <= 1'b0;
        end else if (cancel && (r_state == REQ || r_state == WAIT)) begin
            r_kill <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && w_go) begin
            r_wr    <= write;
            r_size  <= size;
            r_addr  <= addr;
            r_wstrb <= wstrb;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else if (w_cap) begin
            r_rdata <= data_sram_rdata;
        end
    end

    assign data_sram_req   = (r_state == REQ);
    assign data_sram_wr    = r_wr;
    assign data_sram_size  = r_size;
    assign data_sram_addr  = r_addr;
    assign data_sram_wstrb = r_wstrb;
    assign data_sram_wdata = r_wdata;
    assign uc_data_ok      = (r_state == DONE);
    assign uc_rdata        = r_rdata;
    assign uc_busy         = (r_state != IDLE) | w_outstanding;

endmodule

// File: tb/tb_uncached_dm_ctrl.sv
// Directed bench for uncached_dm_ctrl; bus handshakes driven cycle by cycle.
// Inputs change and outputs are sampled on the falling edge.
module tb_uncached_dm_ctrl;
    import dm_uc_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        read, write, uncached, cancel, mem_advance;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        uc_data_ok;
    logic [31:0] uc_rdata;
    logic        uc_busy;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;

    uncached_dm_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .read              (read),
        .write             (write),
        .uncached          (uncached),
        .cancel            (cancel),
        .mem_advance       (mem_advance),
        .addr              (addr),
        .size              (size),
        .wstrb             (wstrb),
        .wdata             (wdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .uc_data_ok        (uc_data_ok),
        .uc_rdata          (uc_rdata),
        .uc_busy           (uc_busy)
    );

    always #5 clk = ~clk;

    // Count accepted bus requests (handshake on the rising edge).
    always @(posedge clk) begin
        if (resetn && data_sram_req && data_sram_addr_ok) n_acc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        logic [31:0] got;
        got = {data_sram_req, data_sram_wr, data_sram_size,
               uc_data_ok, uc_busy, data_sram_wstrb};
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL reset_ctl: got %h want 0", got);
        end
        checks++;
        if ((data_sram_addr | data_sram_wdata | uc_rdata) !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h want 0",
                     data_sram_addr, data_sram_wdata, uc_rdata);
        end
    endtask

    task automatic test_load_basic();
        int acc0;
        int reqs;
        acc0 = n_acc;
        reqs = 0;
        read = 1; uncached = 1; addr = 32'hBFD0_0000; size = SZ_WORD;
        @(negedge clk);
        checks++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'hBFD0_0000 ||
            data_sram_wr !== 1'b0 || data_sram_size !== SZ_WORD) begin
            errors++;
            $display("FAIL lw_req_t1: got req=%b a=%h wr=%b sz=%0d want 1 bfd00000 0 2",
                     data_sram_req, data_sram_addr, data_sram_wr, data_sram_size);
        end
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        if (data_sram_req) reqs++;
        @(negedge clk);
        if (data_sram_req) reqs++;
        checks++;
        if (uc_data_ok !== 1'b0 || uc_busy !== 1'b1) begin
            errors++;
            $display("FAIL lw_wait: got ok=%b busy=%b want 0 1", uc_data_ok, uc_busy);
        end
        @(negedge clk);
        if (data_sram_req) reqs++;
        data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        data_sram_data_ok = 0; data_sram_rdata = 32'h0;
        checks++;
        if (reqs !== 0) begin
            errors++;
            $display("FAIL lw_req_once: got %0d extra req cycles want 0", reqs);
        end
        checks++;
        if (uc_data_ok !== 1'b1 || uc_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lw_done: got ok=%b rd=%h want 1 12345678", uc_data_ok, uc_rdata);
        end
        mem_advance = 1; read = 0;
        @(negedge clk);
        mem_advance = 0;
        checks++;
        if (uc_data_ok !== 1'b0 || uc_busy !== 1'b0 || n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL lw_idle: got ok=%b busy=%b acc=%0d want 0 0 1",
                     uc_data_ok, uc_busy, n_acc - acc0);
        end
    endtask

    task automatic test_load_hold();
        int acc0;
        int held;
        acc0 = n_acc;
        held = 0;
        read = 1; uncached = 1; addr = 32'hBFD0_0010; size = SZ_WORD;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        data_sram_data_ok = 1; data_sram_rdata = 32'hA5A5_0F0F;
        checks++;
        if (uc_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL hold_early: got ok=%b at T+2 want 0", uc_data_ok);
        end
        @(negedge clk);
        data_sram_data_ok = 0; data_sram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (uc_data_ok === 1'b1 && uc_rdata === 32'hA5A5_0F0F) held++;
            if (i < 2) @(negedge clk);
        end
        checks++;
        if (held !== 3) begin
            errors++;
            $display("FAIL hold_cycles: got %0d held cycles want 3", held);
        end
        mem_advance = 1; read = 0;
        @(negedge clk);
        mem_advance = 0;
        checks++;
        if (uc_data_ok !== 1'b0 || n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL hold_release: got ok=%b acc=%0d want 0 1",
                     uc_data_ok, n_acc - acc0);
        end
    endtask

    task automatic test_cancel_wait();
        int acc0;
        int seen_ok;
        acc0 = n_acc;
        seen_ok = 0;
        read = 1; uncached = 1; addr = 32'hBFD0_0020; size = SZ_WORD;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        cancel = 1; read = 0;
        @(negedge clk);
        cancel = 0;
        checks++;
        if (data_sram_req !== 1'b0 || uc_busy !== 1'b1) begin
            errors++;
            $display("FAIL cancel_wait: got req=%b busy=%b want 0 1", data_sram_req, uc_busy);
        end
        if (uc_data_ok) seen_ok++;
        data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_sram_data_ok = 0;
        for (int i = 0; i < 3; i++) begin
            if (uc_data_ok) seen_ok++;
            @(negedge clk);
        end
        checks++;
        if (seen_ok !== 0 || uc_busy !== 1'b0 || n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL cancel_absorb: got ok_cycles=%0d busy=%b acc=%0d want 0 0 1",
                     seen_ok, uc_busy, n_acc - acc0);
        end
    endtask

    task automatic test_store_delay();
        int acc0;
        int stable;
        acc0 = n_acc;
        stable = 0;
        write = 1; uncached = 1; addr = 32'hBFD0_0002; size = SZ_BYTE;
        wstrb = 4'b0100; wdata = 32'h00AB_0000;
        @(negedge clk);
        addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            if (data_sram_req === 1'b1 && data_sram_wr === 1'b1 &&
                data_sram_addr === 32'hBFD0_0002 && data_sram_size === SZ_BYTE &&
                data_sram_wstrb === 4'b0100 && data_sram_wdata === 32'h00AB_0000)
                stable++;
            if (i == 2) data_sram_addr_ok = 1;
            @(negedge clk);
        end
        data_sram_addr_ok = 0;
        checks++;
        if (stable !== 3) begin
            errors++;
            $display("FAIL sb_stable: got %0d stable cycles want 3", stable);
        end
        checks++;
        if (data_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL sb_req_drop: got %b want 0", data_sram_req);
        end
`ifdef UNCACHED_POSTED_WRITE_EN
        checks++;
        if (uc_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL sb_posted_ok: got %b want 1", uc_data_ok);
        end
        mem_advance = 1; write = 0;
        @(negedge clk);
        mem_advance = 0;
        data_sram_data_ok = 1;
        @(negedge clk);
        data_sram_data_ok = 0;
`else
        data_sram_data_ok = 1;
        @(negedge clk);
        data_sram_data_ok = 0;
        checks++;
        if (uc_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL sb_done: got %b want 1", uc_data_ok);
        end
        mem_advance = 1; write = 0;
        @(negedge clk);
        mem_advance = 0;
`endif
        checks++;
        if (uc_busy !== 1'b0 || n_acc - acc0 !== 1) begin
            errors++;
            $display("FAIL sb_one_txn: got busy=%b acc=%0d want 0 1", uc_busy, n_acc - acc0);
        end
    endtask

`ifdef UNCACHED_POSTED_WRITE_EN
    task automatic test_posted();
        int busy_cnt;
        busy_cnt = 0;
        write = 1; uncached = 1; addr = 32'hBFD0_0100; size = SZ_WORD;
        wstrb = 4'hF; wdata = 32'h1111_2222;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        checks++;
        if (uc_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL posted_sw_ok: got %b want 1", uc_data_ok);
        end
        mem_advance = 1; write = 0; read = 1; addr = 32'hBFD0_0200;
        @(negedge clk);
        mem_advance = 0;
        for (int i = 0; i < 2; i++) begin
            if (uc_busy === 1'b1 && data_sram_req === 1'b0) busy_cnt++;
            if (i == 1) data_sram_data_ok = 1;
            @(negedge clk);
        end
        data_sram_data_ok = 0;
        checks++;
        if (busy_cnt !== 2) begin
            errors++;
            $display("FAIL posted_withhold: got %0d good cycles want 2", busy_cnt);
        end
        checks++;
        if (data_sram_req !== 1'b1 || uc_busy !== 1'b1 || data_sram_wr !== 1'b0) begin
            errors++;
            $display("FAIL posted_lw_req: got req=%b busy=%b wr=%b want 1 1 0",
                     data_sram_req, uc_busy, data_sram_wr);
        end
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        data_sram_data_ok = 1; data_sram_rdata = 32'h7777_8888;
        @(negedge clk);
        data_sram_data_ok = 0;
        checks++;
        if (uc_data_ok !== 1'b1 || uc_rdata !== 32'h7777_8888) begin
            errors++;
            $display("FAIL posted_lw_done: got ok=%b rd=%h want 1 77778888", uc_data_ok, uc_rdata);
        end
        mem_advance = 1; read = 0;
        @(negedge clk);
        mem_advance = 0;
    endtask
`endif

    task automatic test_reset_mid();
        read = 1; uncached = 1; addr = 32'hBFD0_0030; size = SZ_WORD;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        resetn = 0; read = 0;
        #1;
        checks++;
        if ({data_sram_req, uc_data_ok, uc_busy, data_sram_wr} !== 4'b0 ||
            data_sram_addr !== 32'h0 || uc_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got req=%b ok=%b busy=%b a=%h rd=%h want all 0",
                     data_sram_req, uc_data_ok, uc_busy, data_sram_addr, uc_rdata);
        end
        @(negedge clk);
        resetn = 1;
        data_sram_data_ok = 1; data_sram_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        data_sram_data_ok = 0;
        checks++;
        if (uc_data_ok !== 1'b0 || uc_busy !== 1'b0 || uc_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_ignore: got ok=%b busy=%b rd=%h want 0 0 0",
                     uc_data_ok, uc_busy, uc_rdata);
        end
        read = 1; addr = 32'hBFD0_0040;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0;
        data_sram_data_ok = 1; data_sram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        data_sram_data_ok = 0;
        checks++;
        if (uc_data_ok !== 1'b1 || uc_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rst_after_lw: got ok=%b rd=%h want 1 cafef00d", uc_data_ok, uc_rdata);
        end
        mem_advance = 1; read = 0;
        @(negedge clk);
        mem_advance = 0;
    endtask

    task automatic test_cached();
        read = 1; uncached = 0; addr = 32'h8000_0000;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data_sram_req !== 1'b0 || uc_busy !== 1'b0) begin
            errors++;
            $display("FAIL cached_idle: got req=%b busy=%b want 0 0", data_sram_req, uc_busy);
        end
        read = 0;
    endtask

    initial begin
        resetn = 0;
        read = 0; write = 0; uncached = 0; cancel = 0; mem_advance = 0;
        addr = 0; size = 0; wstrb = 0; wdata = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        repeat (2) @(negedge clk);
        test_reset();
        resetn = 1;
        @(negedge clk);
        test_load_basic();
        test_load_hold();
        test_cancel_wait();
        test_store_delay();
`ifdef UNCACHED_POSTED_WRITE_EN
        test_posted();
`endif
        test_cached();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
